// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and types for the memory-stage load/store
//                unit: opcodes, load-size encodings, FSM states, M register.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Major opcodes that reach the data bus
  localparam logic [6:0] c_opc_load  = 7'b0000011;
  localparam logic [6:0] c_opc_store = 7'b0100011;

  // Access size encodings (10 is reserved and treated as a word)
  localparam logic [1:0] c_ldsz_byte = 2'b00;
  localparam logic [1:0] c_ldsz_half = 2'b01;
  localparam logic [1:0] c_ldsz_rsvd = 2'b10;
  localparam logic [1:0] c_ldsz_word = 2'b11;

  // Bus transaction sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Memory-stage pipeline register; all-zero is a bubble
  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [4:0]  rd;
    logic [29:0] addr;        // word address, byte offset lives in shift
    logic [31:0] wdata;
    logic [1:0]  ldsz;
    logic [1:0]  shift;
    logic        is_unsigned;
  } m_reg_t;

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Combinational extraction and sign/zero extension of load
//                data returned on the data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ldsz,
  input  logic [1:0]  shift,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, then extend it to 32 bits
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    data   = rdata;
    case (shift)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = shift[1] ? rdata[31:16] : rdata[15:0];
    case (ldsz)
      c_ldsz_byte: data = {{24{~load_unsigned & w_byte[7]}}, w_byte};
      c_ldsz_half: data = {{16{~load_unsigned & w_half[15]}}, w_half};
      default:     data = rdata;   // word and reserved encoding
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Memory pipeline stage. Captures the EX stage outputs,
//                runs load/store transactions on a req/gnt + rvalid data bus
//                and stalls EX while a transaction is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  // From EX
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_wdata,
  input  logic [1:0]  ex_ldsz,
  input  logic [1:0]  ex_ldshift,
  input  logic        ex_unsigned,
  input  logic        ex_trap,
  // To EX / forwarding / writeback
  output logic        stall,
  output logic [4:0]  rd_mem,
  output logic [31:0] res_mem,
  // Data bus
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;
  m_reg_t      r_m;
  m_reg_t      w_m_capture;
  logic [31:0] r_result;
  logic [31:0] w_load_data;
  logic        w_capture;
  logic        w_live;

  // The M register only advances when no transaction holds the stage
  assign w_capture = ~stall;
  // Trapped or invalid instructions are reduced to bubbles
  assign w_live    = ex_valid & ~ex_trap;

  // Build the value the M register takes on a capture
  always_comb begin
    w_m_capture = '0;
    if (w_live) begin
      w_m_capture.is_load     = (ex_opcode == c_opc_load);
      w_m_capture.is_store    = (ex_opcode == c_opc_store);
      w_m_capture.rd          = ex_rd;
      w_m_capture.addr        = ex_res[31:2];
      w_m_capture.wdata       = ex_wdata;
      w_m_capture.ldsz        = ex_ldsz;
      w_m_capture.shift       = ex_ldshift;
      w_m_capture.is_unsigned = ex_unsigned;
    end
  end

  // M register: holds the instruction for the life of its transaction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m <= '0;
    end else if (w_capture) begin
      r_m <= w_m_capture;
    end
  end

  // Stage result: ALU value on capture, replaced by load data on rvalid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_result <= 32'h0;
    end else if (w_capture) begin
      r_result <= w_live ? ex_res : 32'h0;
    end else if (r_state == ST_WAIT && dbus_rvalid) begin
      r_result <= w_load_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the state-decoded handshake and writeback outputs
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    dbus_req     = 1'b0;
    rd_mem       = 5'd0;
    case (r_state)
      ST_IDLE: begin
        rd_mem       = r_m.rd;
        w_state_next = (w_m_capture.is_load | w_m_capture.is_store) ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        stall    = 1'b1;
        dbus_req = 1'b1;
        if (dbus_gnt) begin
          w_state_next = r_m.is_store ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dbus_rvalid) begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        // DONE: result visible for one cycle; next op may start straight away
        rd_mem       = r_m.is_load ? r_m.rd : 5'd0;
        w_state_next = (w_m_capture.is_load | w_m_capture.is_store) ? ST_REQ : ST_IDLE;
      end
    endcase
  end

  // Store lane replication and byte enables derived from size and offset
  always_comb begin
    dbus_wdata = r_m.wdata;
    dbus_be    = 4'h0;
    case (r_m.ldsz)
      c_ldsz_byte: begin
        dbus_wdata = {4{r_m.wdata[7:0]}};
        dbus_be    = 4'b0001 << r_m.shift;
      end
      c_ldsz_half: begin
        dbus_wdata = {2{r_m.wdata[15:0]}};
        dbus_be    = 4'b0011 << {r_m.shift[1], 1'b0};
      end
      default: begin
        dbus_wdata = r_m.wdata;
        dbus_be    = 4'hF;
      end
    endcase
    if (!r_m.is_store) begin
      dbus_be = 4'h0;
    end
  end

  assign dbus_addr = {r_m.addr, 2'b00};
  assign dbus_we   = r_m.is_store;
  assign res_mem   = r_result;

  mem_load_align u_load_align (
    .rdata         (dbus_rdata),
    .ldsz          (r_m.ldsz),
    .shift         (r_m.shift),
    .load_unsigned (r_m.is_unsigned),
    .data          (w_load_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Scoreboard bench for mem_lsu with a bus responder model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd;
  logic [31:0] ex_res;
  logic [31:0] ex_wdata;
  logic [1:0]  ex_ldsz;
  logic [1:0]  ex_ldshift;
  logic        ex_unsigned;
  logic        ex_trap;
  logic        stall;
  logic [4:0]  rd_mem;
  logic [31:0] res_mem;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          gnt_dly;
    int          rv_dly;
    bit          is_load;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } wb_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  wb_t   wb_q[$];

  mem_lsu dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_rd       (ex_rd),
    .ex_res      (ex_res),
    .ex_wdata    (ex_wdata),
    .ex_ldsz     (ex_ldsz),
    .ex_ldshift  (ex_ldshift),
    .ex_unsigned (ex_unsigned),
    .ex_trap     (ex_trap),
    .stall       (stall),
    .rd_mem      (rd_mem),
    .res_mem     (res_mem),
    .dbus_req    (dbus_req),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_wdata  (dbus_wdata),
    .dbus_be     (dbus_be),
    .dbus_gnt    (dbus_gnt),
    .dbus_rvalid (dbus_rvalid),
    .dbus_rdata  (dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one instruction; it is captured on the first edge with stall low
  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] wd, input logic [1:0] sz, input logic [1:0] sh,
                       input logic uns, input logic trap);
    int n;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("issue_timeout", 32'd1, 32'd0);
    ex_valid    = 1'b1;
    ex_opcode   = op;
    ex_rd       = rd;
    ex_res      = res;
    ex_wdata    = wd;
    ex_ldsz     = sz;
    ex_ldshift  = sh;
    ex_unsigned = uns;
    ex_trap     = trap;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_trap  = 1'b0;
  endtask

  // Number of consecutive stalled cycles following a capture
  task automatic count_stall(output int n);
    n = 0;
    @(negedge clk);
    #2;
    while (stall && n < 50) begin
      n++;
      @(negedge clk);
      #2;
    end
  endtask

  function automatic resp_t rsp(input int g, input int r, input bit ld, input logic [31:0] d);
    resp_t x;
    x.gnt_dly = g;
    x.rv_dly  = r;
    x.is_load = ld;
    x.rdata   = d;
    return x;
  endfunction

  function automatic bus_t bexp(input logic [31:0] a, input logic we, input logic [31:0] d,
                                input logic [3:0] be);
    bus_t x;
    x.addr  = a;
    x.we    = we;
    x.wdata = d;
    x.be    = be;
    return x;
  endfunction

  function automatic wb_t wexp(input logic [4:0] rd, input logic [31:0] res);
    wb_t x;
    x.rd  = rd;
    x.res = res;
    return x;
  endfunction

  // Bus responder: grants after a per-transaction delay, returns load data
  initial begin
    resp_t r;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (dbus_req) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected_req: got req=1 addr=0x%08h expected no request", dbus_addr);
        end else begin
          r = resp_q.pop_front();
          repeat (r.gnt_dly) @(negedge clk);
          dbus_gnt = 1'b1;
          @(negedge clk);
          dbus_gnt = 1'b0;
          if (r.is_load) begin
            repeat (r.rv_dly) @(negedge clk);
            dbus_rvalid = 1'b1;
            dbus_rdata  = r.rdata;
            @(negedge clk);
            dbus_rvalid = 1'b0;
            dbus_rdata  = 32'h0;
          end
        end
      end
    end
  end

  // Bus monitor: compare request fields at each accepted handshake
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      #2;
      if (dbus_req && dbus_gnt) begin
        if (bus_q.size() == 0) begin
          chk("bus_handshake_unexpected", 32'd1, 32'd0);
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr", dbus_addr, e.addr);
          chk("bus_we", {31'd0, dbus_we}, {31'd0, e.we});
          chk("bus_wdata", dbus_wdata, e.wdata);
          chk("bus_be", {28'd0, dbus_be}, {28'd0, e.be});
        end
      end
    end
  end

  // Writeback monitor: every non-stalled cycle with a destination register
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!stall && rd_mem != 5'd0) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected_rd", {27'd0, rd_mem}, 32'd0);
        end else begin
          e = wb_q.pop_front();
          chk("wb_rd", {27'd0, rd_mem}, {27'd0, e.rd});
          chk("wb_res", res_mem, e.res);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    ex_valid    = 1'b0;
    ex_opcode   = 7'd0;
    ex_rd       = 5'd0;
    ex_res      = 32'h0;
    ex_wdata    = 32'h0;
    ex_ldsz     = 2'd0;
    ex_ldshift  = 2'd0;
    ex_unsigned = 1'b0;
    ex_trap     = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd_mem", {27'd0, rd_mem}, 32'd0);
    chk("rst_res_mem", res_mem, 32'h0);
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_we", {31'd0, dbus_we}, 32'd0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wdata, 32'h0);
    chk("rst_be", {28'd0, dbus_be}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU results, back to back
    wb_q.push_back(wexp(5'd5, 32'h0000_1234));
    wb_q.push_back(wexp(5'd6, 32'h0000_0055));
    issue(OP_ADD, 5'd5, 32'h0000_1234, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0);
    issue(OP_ADD, 5'd6, 32'h0000_0055, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("alu_stall", {31'd0, stall}, 32'd0);

    // SB at byte 3, grant after two waiting cycles
    bus_q.push_back(bexp(32'h0000_0100, 1'b1, 32'hABAB_ABAB, 4'b1000));
    resp_q.push_back(rsp(2, 0, 1'b0, 32'h0));
    issue(OP_STORE, 5'd7, 32'h0000_0103, 32'h0000_00AB, 2'b00, 2'd3, 1'b0, 1'b0);
    count_stall(n);
    chk("sb_stall_cycles", n, 32'd3);

    // LB signed / LBU from lane 2
    bus_q.push_back(bexp(32'h0000_0200, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(0, 0, 1'b1, 32'h0080_0000));
    wb_q.push_back(wexp(5'd10, 32'hFFFF_FF80));
    issue(OP_LOAD, 5'd10, 32'h0000_0202, 32'h0, 2'b00, 2'd2, 1'b0, 1'b0);
    count_stall(n);
    chk("lb_stall_cycles", n, 32'd2);

    bus_q.push_back(bexp(32'h0000_0200, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(0, 0, 1'b1, 32'h0080_0000));
    wb_q.push_back(wexp(5'd11, 32'h0000_0080));
    issue(OP_LOAD, 5'd11, 32'h0000_0202, 32'h0, 2'b00, 2'd2, 1'b1, 1'b0);

    // LH upper half, LW
    bus_q.push_back(bexp(32'h0000_0200, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(0, 0, 1'b1, 32'h8001_0000));
    wb_q.push_back(wexp(5'd12, 32'hFFFF_8001));
    issue(OP_LOAD, 5'd12, 32'h0000_0202, 32'h0, 2'b01, 2'd2, 1'b0, 1'b0);

    bus_q.push_back(bexp(32'h0000_0200, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(0, 0, 1'b1, 32'h8001_0000));
    wb_q.push_back(wexp(5'd13, 32'h8001_0000));
    issue(OP_LOAD, 5'd13, 32'h0000_0200, 32'h0, 2'b11, 2'd0, 1'b0, 1'b0);

    // LHU lower half with delayed grant and delayed data
    bus_q.push_back(bexp(32'h0000_0208, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(1, 1, 1'b1, 32'h1234_F00D));
    wb_q.push_back(wexp(5'd16, 32'h0000_F00D));
    issue(OP_LOAD, 5'd16, 32'h0000_0208, 32'h0, 2'b01, 2'd0, 1'b1, 1'b0);
    count_stall(n);
    chk("lhu_stall_cycles", n, 32'd4);

    // LB signed from lane 1, positive byte
    bus_q.push_back(bexp(32'h0000_020C, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(0, 0, 1'b1, 32'h0000_7F00));
    wb_q.push_back(wexp(5'd17, 32'h0000_007F));
    issue(OP_LOAD, 5'd17, 32'h0000_020D, 32'h0, 2'b00, 2'd1, 1'b0, 1'b0);

    // SH to the upper half, SW via the reserved size code
    bus_q.push_back(bexp(32'h0000_0300, 1'b1, 32'h5678_5678, 4'b1100));
    resp_q.push_back(rsp(0, 0, 1'b0, 32'h0));
    issue(OP_STORE, 5'd0, 32'h0000_0302, 32'h1234_5678, 2'b01, 2'd2, 1'b0, 1'b0);
    count_stall(n);
    chk("sh_stall_cycles", n, 32'd1);

    bus_q.push_back(bexp(32'h0000_0300, 1'b1, 32'hDEAD_BEEF, 4'hF));
    resp_q.push_back(rsp(0, 0, 1'b0, 32'h0));
    issue(OP_STORE, 5'd8, 32'h0000_0300, 32'hDEAD_BEEF, 2'b10, 2'd0, 1'b0, 1'b0);

    // ALU op right behind the store, captured in the DONE cycle
    wb_q.push_back(wexp(5'd9, 32'h0000_0077));
    issue(OP_ADD, 5'd9, 32'h0000_0077, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0);

    // Reset while waiting for load data; the late rvalid must be ignored
    bus_q.push_back(bexp(32'h0000_0400, 1'b0, 32'h0, 4'h0));
    resp_q.push_back(rsp(0, 2, 1'b1, 32'h1111_1111));
    issue(OP_LOAD, 5'd14, 32'h0000_0400, 32'h0, 2'b11, 2'd0, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    #2;
    while (!(dbus_req && dbus_gnt) && n < 50) begin
      n++;
      @(negedge clk);
      #2;
    end
    chk("rstwait_handshake_seen", {31'd0, dbus_req & dbus_gnt}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #2;
    chk("rstwait_req", {31'd0, dbus_req}, 32'd0);
    chk("rstwait_stall", {31'd0, stall}, 32'd0);
    chk("rstwait_rd_mem", {27'd0, rd_mem}, 32'd0);
    chk("rstwait_res_mem", res_mem, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rstwait_late_rvalid_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    chk("rstwait_after_res", res_mem, 32'h0);
    chk("rstwait_after_rd", {27'd0, rd_mem}, 32'd0);
    chk("rstwait_after_req", {31'd0, dbus_req}, 32'd0);

    // Trapped LW then an immediate SW
    issue(OP_LOAD, 5'd15, 32'h0000_0500, 32'h0, 2'b11, 2'd0, 1'b0, 1'b1);
    bus_q.push_back(bexp(32'h0000_0504, 1'b1, 32'hCAFE_F00D, 4'hF));
    resp_q.push_back(rsp(0, 0, 1'b0, 32'h0));
    fork
      issue(OP_STORE, 5'd0, 32'h0000_0504, 32'hCAFE_F00D, 2'b11, 2'd0, 1'b0, 1'b0);
      begin
        @(negedge clk);
        #2;
        chk("trap_stall", {31'd0, stall}, 32'd0);
        chk("trap_rd_mem", {27'd0, rd_mem}, 32'd0);
        chk("trap_req", {31'd0, dbus_req}, 32'd0);
      end
    join
    count_stall(n);
    chk("sw_after_trap_stall", n, 32'd1);

    // Drain
    n = 0;
    while ((wb_q.size() != 0 || bus_q.size() != 0 || resp_q.size() != 0) && n < 50) begin
      n++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("wb_queue_empty", wb_q.size(), 32'd0);
    chk("bus_queue_empty", bus_q.size(), 32'd0);
    chk("resp_queue_empty", resp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
